// File: rtl/csr_file_if.sv
// CSR access bus between the pipeline (master) and the CSR file (slave).
// Reads are combinational; writes commit on the next rising clock edge.
interface csr_file_if;
  logic [11:0] raddr_i;
  logic [31:0] rdata_o;
  logic        csr_illegal_o;
  logic        we_i;
  logic [11:0] waddr_i;
  logic [31:0] wdata_i;

  modport master (
    output raddr_i, we_i, waddr_i, wdata_i,
    input  rdata_o, csr_illegal_o
  );

  modport slave (
    input  raddr_i, we_i, waddr_i, wdata_i,
    output rdata_o, csr_illegal_o
  );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file for the RV32I core: Zicsr read/write port, trap/mret
// update strobes from the trap controller, synchronised interrupt pendings, 64-bit counters.
module csr_file #(
  parameter logic [31:0] MTVEC_RESET     = 32'h0000_0000,
  parameter logic [31:0] HART_ID         = 32'h0000_0000,
  parameter logic [31:0] MISA_VALUE      = 32'h4000_0100,
  parameter int          IRQ_SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        n_rst_i,
  csr_file_if.slave   bus,
  input  logic        instret_i,
  input  logic        irq_external_i,
  input  logic        irq_timer_i,
  input  logic        irq_software_i,
  input  logic        set_cause_i,
  input  logic [3:0]  trap_cause_i,
  input  logic        ie_type_i,
  input  logic        set_epc_i,
  input  logic [31:0] epc_i,
  input  logic        set_mtval_i,
  input  logic [31:0] mtval_i,
  input  logic        mstatus_ie_clear_i,
  input  logic        mstatus_ie_set_i,
  output logic        mstatus_ie_o,
  output logic        mie_external_o,
  output logic        mie_timer_o,
  output logic        mie_sw_o,
  output logic        mip_external_o,
  output logic        mip_timer_o,
  output logic        mip_sw_o,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o
);

  localparam logic [11:0] A_MSTATUS   = 12'h300, A_MISA     = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304, A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340, A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342, A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00, A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02, A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00, A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRET   = 12'hC02, A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_MVENDORID = 12'hF11, A_MHARTID   = 12'hF14;

  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
  localparam logic [31:0] MSTATUS_FIXED = 32'h0000_1800;
  localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;
  localparam logic [31:0] MTVEC_WMASK   = 32'hFFFF_FFFD;
  localparam logic [31:0] MEPC_WMASK    = 32'hFFFF_FFFC;
  localparam logic [31:0] MCAUSE_WMASK  = 32'h8000_000F;

  logic        r_mstatus_mie, r_mstatus_mpie;
  logic        r_mie_ext, r_mie_tim, r_mie_sw;
  logic [31:0] r_mtvec, r_mscratch, r_mepc, r_mtval;
  logic        r_mcause_int;
  logic [3:0]  r_mcause_code;
  logic [63:0] r_mcycle, r_minstret;
  logic [2:0][IRQ_SYNC_STAGES-1:0] r_irq_pipe;

  logic [2:0]  w_irq_raw;
  logic [2:0]  w_mip;
  logic        w_writable;
  logic [31:0] w_wdata_m;
  logic [31:0] w_rd_val;
  logic        w_rd_ill;
  logic        w_mstatus_strobe;
  logic        w_we_mstatus, w_we_mie, w_we_mtvec, w_we_mscratch;
  logic        w_we_mepc, w_we_mcause, w_we_mtval;
  logic        w_we_mcyc_lo, w_we_mcyc_hi, w_we_mins_lo, w_we_mins_hi;

  // Write-side decode: which addresses accept writes, and the value after masking.
  always_comb begin
    w_writable = 1'b1;
    w_wdata_m  = bus.wdata_i;
    case (bus.waddr_i)
      A_MSTATUS:  w_wdata_m = (bus.wdata_i & MSTATUS_WMASK) | MSTATUS_FIXED;
      A_MIE:      w_wdata_m = bus.wdata_i & MIE_WMASK;
      A_MTVEC:    w_wdata_m = bus.wdata_i & MTVEC_WMASK;
      A_MEPC:     w_wdata_m = bus.wdata_i & MEPC_WMASK;
      A_MCAUSE:   w_wdata_m = bus.wdata_i & MCAUSE_WMASK;
      A_MSCRATCH, A_MTVAL, A_MCYCLE, A_MCYCLEH, A_MINSTRET, A_MINSTRETH: ;
      default:    w_writable = 1'b0;
    endcase
  end

  assign w_mstatus_strobe = mstatus_ie_clear_i | mstatus_ie_set_i;
  assign w_we_mstatus  = bus.we_i && bus.waddr_i == A_MSTATUS && !w_mstatus_strobe;
  assign w_we_mie      = bus.we_i && bus.waddr_i == A_MIE;
  assign w_we_mtvec    = bus.we_i && bus.waddr_i == A_MTVEC;
  assign w_we_mscratch = bus.we_i && bus.waddr_i == A_MSCRATCH;
  assign w_we_mepc     = bus.we_i && bus.waddr_i == A_MEPC;
  assign w_we_mcause   = bus.we_i && bus.waddr_i == A_MCAUSE;
  assign w_we_mtval    = bus.we_i && bus.waddr_i == A_MTVAL;
  assign w_we_mcyc_lo  = bus.we_i && bus.waddr_i == A_MCYCLE;
  assign w_we_mcyc_hi  = bus.we_i && bus.waddr_i == A_MCYCLEH;
  assign w_we_mins_lo  = bus.we_i && bus.waddr_i == A_MINSTRET;
  assign w_we_mins_hi  = bus.we_i && bus.waddr_i == A_MINSTRETH;

  // Trap-controller strobes take priority over a software write to the same CSR.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie_ext      <= 1'b0;
      r_mie_tim      <= 1'b0;
      r_mie_sw       <= 1'b0;
      r_mtvec        <= MTVEC_RESET;
      r_mscratch     <= '0;
      r_mepc         <= '0;
      r_mcause_int   <= 1'b0;
      r_mcause_code  <= '0;
      r_mtval        <= '0;
    end else begin
      if (mstatus_ie_clear_i) begin
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
      end else if (mstatus_ie_set_i) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
      end else if (w_we_mstatus) begin
        r_mstatus_mie  <= w_wdata_m[3];
        r_mstatus_mpie <= w_wdata_m[7];
      end
      if (w_we_mie) begin
        r_mie_ext <= w_wdata_m[11];
        r_mie_tim <= w_wdata_m[7];
        r_mie_sw  <= w_wdata_m[3];
      end
      if (w_we_mtvec)    r_mtvec    <= w_wdata_m;
      if (w_we_mscratch) r_mscratch <= w_wdata_m;
      if (set_epc_i)      r_mepc <= epc_i & MEPC_WMASK;
      else if (w_we_mepc) r_mepc <= w_wdata_m;
      if (set_cause_i) begin
        r_mcause_int  <= ie_type_i;
        r_mcause_code <= trap_cause_i;
      end else if (w_we_mcause) begin
        r_mcause_int  <= w_wdata_m[31];
        r_mcause_code <= w_wdata_m[3:0];
      end
      if (set_mtval_i)     r_mtval <= mtval_i;
      else if (w_we_mtval) r_mtval <= w_wdata_m;
    end
  end

  // A write to either half freezes that counter for the cycle.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      if (w_we_mcyc_lo)      r_mcycle[31:0]  <= bus.wdata_i;
      else if (w_we_mcyc_hi) r_mcycle[63:32] <= bus.wdata_i;
      else                   r_mcycle        <= r_mcycle + 64'd1;
      if (w_we_mins_lo)      r_minstret[31:0]  <= bus.wdata_i;
      else if (w_we_mins_hi) r_minstret[63:32] <= bus.wdata_i;
      else if (instret_i)    r_minstret        <= r_minstret + 64'd1;
    end
  end

  assign w_irq_raw = {irq_external_i, irq_timer_i, irq_software_i};

  for (genvar g = 0; g < 3; g++) begin : g_irq_sync
    always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
        r_irq_pipe[g] <= '0;
      end else begin
        r_irq_pipe[g][0] <= w_irq_raw[g];
        for (int i = 1; i < IRQ_SYNC_STAGES; i++)
          r_irq_pipe[g][i] <= r_irq_pipe[g][i-1];
      end
    end
    assign w_mip[g] = r_irq_pipe[g][IRQ_SYNC_STAGES-1];
  end

  always_comb begin
    w_rd_val = '0;
    w_rd_ill = 1'b0;
    case (bus.raddr_i)
      A_MSTATUS:   w_rd_val = MSTATUS_FIXED | {24'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};
      A_MISA:      w_rd_val = MISA_VALUE;
      A_MIE:       w_rd_val = {20'b0, r_mie_ext, 3'b0, r_mie_tim, 3'b0, r_mie_sw, 3'b0};
      A_MTVEC:     w_rd_val = r_mtvec;
      A_MSCRATCH:  w_rd_val = r_mscratch;
      A_MEPC:      w_rd_val = r_mepc;
      A_MCAUSE:    w_rd_val = {r_mcause_int, 27'b0, r_mcause_code};
      A_MTVAL:     w_rd_val = r_mtval;
      A_MIP:       w_rd_val = {20'b0, w_mip[2], 3'b0, w_mip[1], 3'b0, w_mip[0], 3'b0};
      A_MCYCLE,   A_CYCLE:    w_rd_val = r_mcycle[31:0];
      A_MCYCLEH,  A_CYCLEH:   w_rd_val = r_mcycle[63:32];
      A_MINSTRET, A_INSTRET:  w_rd_val = r_minstret[31:0];
      A_MINSTRETH, A_INSTRETH: w_rd_val = r_minstret[63:32];
      A_MHARTID:   w_rd_val = HART_ID;
      A_MVENDORID: w_rd_val = '0;
      default:     w_rd_ill = 1'b1;
    endcase
  end

  // Same-cycle write to the read address is forwarded, already masked.
  assign bus.rdata_o       = (bus.we_i && w_writable && bus.waddr_i == bus.raddr_i) ? w_wdata_m : w_rd_val;
  assign bus.csr_illegal_o = w_rd_ill;

  assign mstatus_ie_o   = r_mstatus_mie;
  assign mie_external_o = r_mie_ext;
  assign mie_timer_o    = r_mie_tim;
  assign mie_sw_o       = r_mie_sw;
  assign mip_external_o = w_mip[2];
  assign mip_timer_o    = w_mip[1];
  assign mip_sw_o       = w_mip[0];
  assign mtvec_o        = r_mtvec;
  assign mepc_o         = r_mepc;

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: register table plus trap, forwarding, irq and counter sequences.
module tb_csr_file;
  localparam logic [31:0] MTVEC_RST = 32'h0000_1000;
  localparam logic [31:0] HARTID    = 32'h0000_0005;
  localparam int          SYNC      = 3;

  logic clk_i = 1'b0;
  logic n_rst_i;
  logic instret_i, irq_external_i, irq_timer_i, irq_software_i;
  logic set_cause_i, ie_type_i, set_epc_i, set_mtval_i;
  logic [3:0]  trap_cause_i;
  logic [31:0] epc_i, mtval_i;
  logic mstatus_ie_clear_i, mstatus_ie_set_i;
  logic mstatus_ie_o, mie_external_o, mie_timer_o, mie_sw_o;
  logic mip_external_o, mip_timer_o, mip_sw_o;
  logic [31:0] mtvec_o, mepc_o;

  csr_file_if bus ();

  csr_file #(.MTVEC_RESET(MTVEC_RST), .HART_ID(HARTID), .MISA_VALUE(32'h4000_0100),
             .IRQ_SYNC_STAGES(SYNC)) dut (
    .clk_i(clk_i), .n_rst_i(n_rst_i), .bus(bus.slave), .instret_i(instret_i),
    .irq_external_i(irq_external_i), .irq_timer_i(irq_timer_i), .irq_software_i(irq_software_i),
    .set_cause_i(set_cause_i), .trap_cause_i(trap_cause_i), .ie_type_i(ie_type_i),
    .set_epc_i(set_epc_i), .epc_i(epc_i), .set_mtval_i(set_mtval_i), .mtval_i(mtval_i),
    .mstatus_ie_clear_i(mstatus_ie_clear_i), .mstatus_ie_set_i(mstatus_ie_set_i),
    .mstatus_ie_o(mstatus_ie_o), .mie_external_o(mie_external_o), .mie_timer_o(mie_timer_o),
    .mie_sw_o(mie_sw_o), .mip_external_o(mip_external_o), .mip_timer_o(mip_timer_o),
    .mip_sw_o(mip_sw_o), .mtvec_o(mtvec_o), .mepc_o(mepc_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        ill;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    string       name;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic [11:0] raddr;
    logic [31:0] exp_rdata;
    logic        exp_ill;
  } vec_t;
  vec_t tbl[14];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Expected read pushed when the address is driven, popped when the read is sampled.
  task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp, input logic ill = 1'b0);
    exp_t e;
    bus.raddr_i = a;
    e.name = name; e.rdata = exp; e.ill = ill;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    chk(e.name, bus.rdata_o, e.rdata);
    chk({e.name, "_ill"}, {31'b0, bus.csr_illegal_o}, {31'b0, e.ill});
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    bus.we_i = 1'b1; bus.waddr_i = a; bus.wdata_i = d;
    step();
    bus.we_i = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{"mscratch",  12'h340, 32'hA5A5_A5A5, 12'h340, 32'hA5A5_A5A5, 1'b0};
    tbl[1]  = '{"mstatus_w", 12'h300, 32'hFFFF_FFFF, 12'h300, 32'h0000_1888, 1'b0};
    tbl[2]  = '{"mie_w",     12'h304, 32'hFFFF_FFFF, 12'h304, 32'h0000_0888, 1'b0};
    tbl[3]  = '{"mtvec_w",   12'h305, 32'h0000_1003, 12'h305, 32'h0000_1001, 1'b0};
    tbl[4]  = '{"mepc_w",    12'h341, 32'hFFFF_FFFF, 12'h341, 32'hFFFF_FFFC, 1'b0};
    tbl[5]  = '{"mcause_w",  12'h342, 32'hFFFF_FFFF, 12'h342, 32'h8000_000F, 1'b0};
    tbl[6]  = '{"mtval_w",   12'h343, 32'h1234_5678, 12'h343, 32'h1234_5678, 1'b0};
    tbl[7]  = '{"mhartid",   12'hF14, 32'hFFFF_FFFF, 12'hF14, HARTID,        1'b0};
    tbl[8]  = '{"misa",      12'h301, 32'h0000_0000, 12'h301, 32'h4000_0100, 1'b0};
    tbl[9]  = '{"unimpl",    12'h7C0, 32'h0000_0001, 12'h7C0, 32'h0000_0000, 1'b1};
    tbl[10] = '{"mvendorid", 12'hF11, 32'h0000_0005, 12'hF11, 32'h0000_0000, 1'b0};
    tbl[11] = '{"mip_ro",    12'h344, 32'hFFFF_FFFF, 12'h344, 32'h0000_0000, 1'b0};
    tbl[12] = '{"mstatus_0", 12'h300, 32'h0000_0000, 12'h300, 32'h0000_1800, 1'b0};
    tbl[13] = '{"mie_0",     12'h304, 32'h0000_0000, 12'h304, 32'h0000_0000, 1'b0};

    n_rst_i = 1'b0;
    bus.raddr_i = 12'h300; bus.we_i = 1'b0; bus.waddr_i = '0; bus.wdata_i = '0;
    instret_i = 0; irq_external_i = 0; irq_timer_i = 0; irq_software_i = 0;
    set_cause_i = 0; trap_cause_i = '0; ie_type_i = 0; set_epc_i = 0; epc_i = '0;
    set_mtval_i = 0; mtval_i = '0; mstatus_ie_clear_i = 0; mstatus_ie_set_i = 0;
    repeat (2) @(negedge clk_i);
    n_rst_i = 1'b1;
    step();

    chk("rst_mtvec", mtvec_o, MTVEC_RST);
    chk("rst_mepc", mepc_o, 32'h0);
    chk("rst_ie_mie_mip", {26'b0, mstatus_ie_o, mie_external_o, mie_timer_o, mie_sw_o,
        mip_timer_o, mip_external_o}, 32'h0);
    rd("rst_mstatus", 12'h300, 32'h0000_1800);
    rd("rst_mie", 12'h304, 32'h0);

    foreach (tbl[i]) begin
      wr(tbl[i].waddr, tbl[i].wdata);
      rd(tbl[i].name, tbl[i].raddr, tbl[i].exp_rdata, tbl[i].exp_ill);
    end

    // Trap entry with MIE=1, then mret.
    wr(12'h300, 32'h8);
    chk("ie_before_trap", {31'b0, mstatus_ie_o}, 32'h1);
    set_cause_i = 1; trap_cause_i = 4'hB; ie_type_i = 1; set_epc_i = 1; epc_i = 32'h100;
    mstatus_ie_clear_i = 1;
    step();
    set_cause_i = 0; set_epc_i = 0; mstatus_ie_clear_i = 0; ie_type_i = 0;
    rd("trap_mcause", 12'h342, 32'h8000_000B);
    chk("trap_mepc", mepc_o, 32'h100);
    rd("trap_mstatus", 12'h300, 32'h0000_1880);
    chk("trap_ie", {31'b0, mstatus_ie_o}, 32'h0);
    mstatus_ie_set_i = 1;
    step();
    mstatus_ie_set_i = 0;
    rd("mret_mstatus", 12'h300, 32'h0000_1888);
    mstatus_ie_clear_i = 1; mstatus_ie_set_i = 1;
    step();
    mstatus_ie_clear_i = 0; mstatus_ie_set_i = 0;
    rd("clr_set_both", 12'h300, 32'h0000_1880);
    mstatus_ie_clear_i = 1;
    wr(12'h300, 32'h8);
    mstatus_ie_clear_i = 0;
    rd("clr_beats_wr", 12'h300, 32'h0000_1800);

    // Strobe vs software write conflicts.
    set_epc_i = 1; epc_i = 32'h300;
    wr(12'h341, 32'h200);
    set_epc_i = 0;
    chk("epc_conflict", mepc_o, 32'h300);
    set_epc_i = 1; epc_i = 32'h400;
    wr(12'h340, 32'h55);
    set_epc_i = 0;
    chk("epc_other_wr", mepc_o, 32'h400);
    rd("mscratch_other", 12'h340, 32'h55);
    set_mtval_i = 1; mtval_i = 32'hDEAD_BEEF;
    wr(12'h343, 32'h1);
    set_mtval_i = 0;
    rd("mtval_conflict", 12'h343, 32'hDEAD_BEEF);
    wr(12'h305, 32'h1003);
    chk("mtvec_o_mask", mtvec_o, 32'h1001);

    // Forwarding within the same cycle.
    bus.we_i = 1; bus.waddr_i = 12'h340; bus.wdata_i = 32'hA5A5_A5A5;
    rd("fwd_mscratch", 12'h340, 32'hA5A5_A5A5);
    bus.waddr_i = 12'h341; bus.wdata_i = 32'hFFFF_FFFF;
    rd("fwd_mepc_mask", 12'h341, 32'hFFFF_FFFC);
    bus.waddr_i = 12'hF14; bus.wdata_i = 32'h77;
    rd("fwd_ro", 12'hF14, HARTID);
    bus.we_i = 0;
    step();

    // Interrupt synchroniser latency, rise and fall.
    wr(12'h304, 32'h80);
    chk("mie_timer_o", {31'b0, mie_timer_o}, 32'h1);
    irq_timer_i = 1;
    for (int k = 1; k <= SYNC; k++) begin
      step();
      chk($sformatf("mip_rise_%0d", k), {31'b0, mip_timer_o}, {31'b0, k == SYNC});
    end
    rd("mip_read", 12'h344, 32'h80);
    irq_timer_i = 0;
    for (int k = 1; k <= SYNC; k++) begin
      step();
      chk($sformatf("mip_fall_%0d", k), {31'b0, mip_timer_o}, {31'b0, k != SYNC});
    end

    // mcycle low-to-high carry.
    wr(12'hB00, 32'hFFFF_FFFF);
    wr(12'hB80, 32'h0);
    step();
    rd("mcycle_wrap", 12'hB00, 32'h0);
    rd("mcycleh_carry", 12'hB80, 32'h1);
    rd("cycleh_shadow", 12'hC80, 32'h1);

    // minstret full wrap.
    wr(12'hB82, 32'hFFFF_FFFF);
    wr(12'hB02, 32'hFFFF_FFFF);
    step();
    rd("minstret_hold", 12'hB02, 32'hFFFF_FFFF);
    instret_i = 1;
    step();
    instret_i = 0;
    rd("minstret_wrap", 12'hB02, 32'h0);
    rd("minstreth_wrap", 12'hB82, 32'h0);
    rd("instreth_shadow", 12'hC82, 32'h0);

    // Asynchronous reset mid-cycle.
    wr(12'h341, 32'h1234);
    #2 n_rst_i = 1'b0;
    #1;
    chk("async_rst_mepc", mepc_o, 32'h0);
    chk("async_rst_mtvec", mtvec_o, MTVEC_RST);
    rd("async_rst_mscratch", 12'h340, 32'h0);
    @(negedge clk_i);
    n_rst_i = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
